acc_seq_ctrl: RTL and testbench

Sequencer for the 3x3 byte-matrix accelerator datapath and its APB register block.
- Accepts a start command and streams operand words into the datapath's operand registers.
- Pulses the datapath start, waits for its done with a timeout, then drains the result words as a valid/ready stream.
- Reports busy/done/timeout and a sticky interrupt, so software no longer polls result words blindly.

---
 rtl/acc_pkg.sv | 20 ++
 rtl/acc_seq_timeout.sv | 39 +++
 rtl/acc_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and default sizing for the matrix accelerator sequencer.
// Optional feature macro: ACC_SEQ_CTRL_PERF_EN (job cycle counter).
package acc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } acc_seq_state_e;

   localparam int ACC_N_OP_WORDS      = 5;
   localparam int ACC_N_RES_WORDS     = 5;
   localparam int ACC_TIMEOUT_DEFAULT = 255;
   localparam int ACC_ADDR_W          = 3;
   localparam int ACC_CNT_W           = 8;
   localparam int ACC_PERF_W          = 16;

endpackage

// File: rtl/acc_seq_timeout.sv
// Run-phase cycle counter: cleared on datapath start, counts while the
// job stays in RUN, flags the terminal count used as the done timeout.
module acc_seq_timeout #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // restart at zero on start or clear, otherwise count while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (start_i || clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/acc_seq_ctrl.sv
// Job sequencer for the 3x3 byte-matrix accelerator: load operands, start,
// wait for done or timeout, drain results. Optional: ACC_SEQ_CTRL_PERF_EN.
module acc_seq_ctrl
   import acc_pkg::*;
#(
   parameter int N_OP_WORDS  = ACC_N_OP_WORDS,
   parameter int N_RES_WORDS = ACC_N_RES_WORDS,
   parameter int ADDR_W      = ACC_ADDR_W,
   parameter int TIMEOUT     = ACC_TIMEOUT_DEFAULT,
   parameter int CNT_W       = ACC_CNT_W
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              irq_clr_i,
   input  logic              op_valid_i,
   output logic              op_ready_o,
   input  logic [31:0]       op_data_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic              acc_start_o,
   input  logic              acc_done_i,
   output logic [ADDR_W-1:0] res_rd_addr_o,
   input  logic [31:0]       res_rd_data_i,
   output logic              res_valid_o,
   output logic [31:0]       res_data_o,
   input  logic              res_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic              irq_o,
   output logic [15:0]       perf_cycles_o
);

   acc_seq_state_e    state_q;
   acc_seq_state_e    state_d;
   logic [ADDR_W-1:0] load_cnt_q;
   logic [ADDR_W-1:0] load_cnt_d;
   logic [ADDR_W-1:0] res_cnt_q;
   logic [ADDR_W-1:0] res_cnt_d;
   logic              acc_start_q;
   logic              acc_start_d;
   logic              done_q;
   logic              done_d;
   logic              timeout_q;
   logic              timeout_d;
   logic              irq_q;
   logic              irq_d;
   logic              run_tc;
   logic              run_en;
   logic              run_clr;

   // next state, word counters and sticky status
   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      res_cnt_d   = res_cnt_q;
      acc_start_d = 1'b0;
      done_d      = done_q;
      timeout_d   = timeout_q;
      irq_d       = irq_q;
      if (irq_clr_i) begin
         irq_d     = 1'b0;
         done_d    = 1'b0;
         timeout_d = 1'b0;
      end
      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d   = LOAD;
               done_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         LOAD: begin
            if (op_valid_i) begin
               if (load_cnt_q == ADDR_W'(N_OP_WORDS - 1)) begin
                  load_cnt_d  = '0;
                  state_d     = RUN;
                  acc_start_d = 1'b1;
               end else begin
                  load_cnt_d = load_cnt_q + 1'b1;
               end
            end
         end
         RUN: begin
            // a done seen with the start pulse is stale, ignore it
            if (acc_done_i && !acc_start_q) begin
               state_d = DRAIN;
            end else if (run_tc) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               irq_d     = 1'b1;
            end
         end
         DRAIN: begin
            if (res_ready_i) begin
               if (res_cnt_q == ADDR_W'(N_RES_WORDS - 1)) begin
                  res_cnt_d = '0;
                  state_d   = DONE;
                  done_d    = 1'b1;
                  irq_d     = 1'b1;
               end else begin
                  res_cnt_d = res_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (abort_i) begin
         state_d     = IDLE;
         load_cnt_d  = '0;
         res_cnt_d   = '0;
         acc_start_d = 1'b0;
         done_d      = 1'b0;
         timeout_d   = 1'b0;
         irq_d       = 1'b0;
      end
   end

   // FSM and status registers
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q     <= IDLE;
         load_cnt_q  <= '0;
         res_cnt_q   <= '0;
         acc_start_q <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         res_cnt_q   <= res_cnt_d;
         acc_start_q <= acc_start_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         irq_q       <= irq_d;
      end
   end

   assign run_en  = (state_q == RUN) && (state_d == RUN);
   assign run_clr = abort_i || ((state_q == RUN) && (state_d != RUN));

   acc_seq_timeout #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (HCLK),
      .rst     (HRESET),
      .start_i (acc_start_d),
      .en_i    (run_en),
      .clr_i   (run_clr),
      .tc_o    (run_tc)
   );

   assign op_ready_o    = (state_q == LOAD);
   assign wr_en_o       = op_valid_i & op_ready_o;
   assign wr_addr_o     = load_cnt_q + 1'b1;
   assign wr_data_o     = op_ready_o ? op_data_i : 32'd0;
   assign acc_start_o   = acc_start_q;
   assign res_rd_addr_o = res_cnt_q + 1'b1;
   assign res_valid_o   = (state_q == DRAIN);
   assign res_data_o    = res_valid_o ? res_rd_data_i : 32'd0;
   assign busy_o        = (state_q == LOAD) || (state_q == RUN) ||
                          (state_q == DRAIN);
   assign done_o        = done_q;
   assign timeout_o     = timeout_q;
   assign irq_o         = irq_q;

`ifdef ACC_SEQ_CTRL_PERF_EN
   logic [ACC_PERF_W-1:0] perf_q;
   logic [ACC_PERF_W-1:0] perf_d;
   logic                  start_acc;

   assign start_acc = start_i && ((state_q == IDLE) || (state_q == DONE));

   // job cycle count: restart on accept, saturate, hold outside the job
   always_comb begin
      perf_d = perf_q;
      if (abort_i || start_acc) begin
         perf_d = '0;
      end else if (busy_o && (perf_q != {ACC_PERF_W{1'b1}})) begin
         perf_d = perf_q + 1'b1;
      end
   end

   // performance counter register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = 16'd0;
`endif

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl: randomized operand/result data,
// directed job sequence checked against a job-level reference model.
module tb_acc_seq_ctrl;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        start_i;
   logic        abort_i;
   logic        irq_clr_i;
   logic        op_valid_i;
   logic        op_ready_o;
   logic [31:0] op_data_i;
   logic        wr_en_o;
   logic [2:0]  wr_addr_o;
   logic [31:0] wr_data_o;
   logic        acc_start_o;
   logic        acc_done_i;
   logic [2:0]  res_rd_addr_o;
   logic [31:0] res_rd_data_i;
   logic        res_valid_o;
   logic [31:0] res_data_o;
   logic        res_ready_i;
   logic        busy_o;
   logic        done_o;
   logic        timeout_o;
   logic        irq_o;
   logic [15:0] perf_cycles_o;

   logic [31:0] res_mem [0:7];
   int          checks = 0;
   int          failures = 0;
   bit          irq_m = 1'b0;

   localparam int TO = 255;

   assign res_rd_data_i = res_mem[res_rd_addr_o];

   always #5 HCLK = ~HCLK;

   acc_seq_ctrl dut (
      .HCLK          (HCLK),
      .HRESET        (HRESET),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .irq_clr_i     (irq_clr_i),
      .op_valid_i    (op_valid_i),
      .op_ready_o    (op_ready_o),
      .op_data_i     (op_data_i),
      .wr_en_o       (wr_en_o),
      .wr_addr_o     (wr_addr_o),
      .wr_data_o     (wr_data_o),
      .acc_start_o   (acc_start_o),
      .acc_done_i    (acc_done_i),
      .res_rd_addr_o (res_rd_addr_o),
      .res_rd_data_i (res_rd_data_i),
      .res_valid_o   (res_valid_o),
      .res_data_o    (res_data_o),
      .res_ready_i   (res_ready_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .timeout_o     (timeout_o),
      .irq_o         (irq_o),
      .perf_cycles_o (perf_cycles_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_in();
      start_i    = 1'b0;
      abort_i    = 1'b0;
      irq_clr_i  = 1'b0;
      op_valid_i = 1'b0;
      op_data_i  = 32'd0;
      acc_done_i = 1'b0;
      res_ready_i = 1'b0;
   endtask

   function automatic logic [15:0] perf_exp(input int n);
`ifdef ACC_SEQ_CTRL_PERF_EN
      return (n > 65535) ? 16'hFFFF : 16'(n);
`else
      return (n > 0) ? 16'd0 : 16'd0;
`endif
   endfunction

   task automatic chk_rst(input string tag);
      chk({tag, "_ready"}, op_ready_o, 0);
      chk({tag, "_wr_en"}, wr_en_o, 0);
      chk({tag, "_wr_addr"}, wr_addr_o, 1);
      chk({tag, "_wr_data"}, wr_data_o, 0);
      chk({tag, "_acc_start"}, acc_start_o, 0);
      chk({tag, "_rd_addr"}, res_rd_addr_o, 1);
      chk({tag, "_res_valid"}, res_valid_o, 0);
      chk({tag, "_res_data"}, res_data_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_timeout"}, timeout_o, 0);
      chk({tag, "_irq"}, irq_o, 0);
      chk({tag, "_perf"}, perf_cycles_o, 0);
   endtask

   // One job. dly: RUN cycle (start cycle = 0) where done is raised, <0 none.
   task automatic job(input int dly, input int gaps, input int stall_w,
                      input bit clr, input bit abort_c, input bit rst_drain);
      logic [31:0] ops [5];
      int bc;
      int pulses;
      bit gone;
      bit bad;
      for (int i = 0; i < 8; i++) res_mem[i] = $urandom;
      for (int i = 0; i < 5; i++) ops[i] = $urandom;
      idle_in();
      start_i   = 1'b1;
      irq_clr_i = clr;
      step();
      idle_in();
      if (clr) irq_m = 1'b0;
      chk("load_busy", busy_o, 1);
      chk("load_ready", op_ready_o, 1);
      chk("start_irq", irq_o, irq_m);
      chk("start_done", done_o, 0);
      chk("start_timeout", timeout_o, 0);
      bc = 0;
      for (int i = 0; i < 5; i++) begin
         if (i >= 1 && i <= gaps) begin
            op_valid_i = 1'b0;
            start_i    = 1'b1;
            op_data_i  = $urandom;
            #1;
            chk("gap_wr_en", wr_en_o, 0);
            step();
            bc++;
            start_i = 1'b0;
            chk("gap_addr", wr_addr_o, i + 1);
            chk("gap_ready", op_ready_o, 1);
         end
         op_valid_i = 1'b1;
         op_data_i  = ops[i];
         #1;
         chk("wr_en", wr_en_o, 1);
         chk("wr_addr", wr_addr_o, i + 1);
         chk("wr_data", wr_data_o, ops[i]);
         step();
         bc++;
      end
      idle_in();
      gone   = 1'b0;
      bad    = 1'b0;
      pulses = 0;
      for (int c = 0; c < 300 && !gone; c++) begin
         acc_done_i = (c == dly) || (c == 0 && dly >= 0);
         abort_i    = abort_c && (c == 4);
         #1;
         if (acc_start_o) pulses++;
         if (c == 0) chk("acc_start_first", acc_start_o, 1);
         step();
         bc++;
         acc_done_i = 1'b0;
         abort_i    = 1'b0;
         if (abort_c && c == 4) begin
            irq_m = 1'b0;
            chk_rst("abort");
            return;
         end else if (c == dly) begin
            gone = 1'b1;
            chk("drain_enter", res_valid_o, 1);
         end else if (c == TO) begin
            gone  = 1'b1;
            irq_m = 1'b1;
            chk("to_timeout", timeout_o, 1);
            chk("to_done", done_o, 0);
            chk("to_irq", irq_o, 1);
            chk("to_busy", busy_o, 0);
            chk("to_res_valid", res_valid_o, 0);
            chk("to_perf", perf_cycles_o, perf_exp(bc));
         end else if (res_valid_o || !busy_o || timeout_o) begin
            bad = 1'b1;
         end
      end
      chk("run_stable", bad, 0);
      chk("run_exit", gone, 1);
      chk("start_pulses", pulses, 1);
      if (dly < 0) return;
      for (int w = 1; w <= 5; w++) begin
         if (w == stall_w) begin
            for (int s = 0; s < 3; s++) begin
               res_ready_i = 1'b0;
               #1;
               chk("stall_valid", res_valid_o, 1);
               chk("stall_addr", res_rd_addr_o, w);
               chk("stall_data", res_data_o, res_mem[w]);
               if (rst_drain && s == 1) begin
                  HRESET = 1'b1;
                  #1;
                  chk_rst("rst_drain");
                  step();
                  HRESET = 1'b0;
                  irq_m  = 1'b0;
                  chk_rst("rst_hold");
                  return;
               end
               step();
               bc++;
            end
         end
         res_ready_i = 1'b1;
         #1;
         chk("res_valid", res_valid_o, 1);
         chk("res_addr", res_rd_addr_o, w);
         chk("res_data", res_data_o, res_mem[w]);
         step();
         bc++;
      end
      idle_in();
      irq_m = 1'b1;
      chk("end_done", done_o, 1);
      chk("end_timeout", timeout_o, 0);
      chk("end_irq", irq_o, 1);
      chk("end_busy", busy_o, 0);
      chk("end_res_valid", res_valid_o, 0);
      chk("end_wr_addr", wr_addr_o, 1);
      chk("end_rd_addr", res_rd_addr_o, 1);
      chk("end_perf", perf_cycles_o, perf_exp(bc));
      step();
      step();
      chk("perf_frozen", perf_cycles_o, perf_exp(bc));
      chk("done_hold", done_o, 1);
   endtask

   initial begin
      HRESET = 1'b1;
      idle_in();
      for (int i = 0; i < 8; i++) res_mem[i] = 32'd0;
      #1;
      chk_rst("reset_async");
      step();
      step();
      HRESET = 1'b0;
      chk_rst("reset");

      // nominal job, done 9 cycles after the start pulse
      job(9, 0, 0, 1'b0, 1'b0, 1'b0);
      // operand gaps and result stall on word 2; start alone keeps irq
      job($urandom_range(1, 20), 2, 2, 1'b0, 1'b0, 1'b0);
      // timeout job, started with simultaneous irq clear
      job(-1, 0, 0, 1'b1, 1'b0, 1'b0);
      // irq clear alone in DONE
      irq_clr_i = 1'b1;
      step();
      idle_in();
      irq_m = 1'b0;
      chk("clr_irq", irq_o, 0);
      chk("clr_timeout", timeout_o, 0);
      chk("clr_busy", busy_o, 0);
      // done arriving on the terminal count cycle still drains
      job(TO, 0, 0, 1'b0, 1'b0, 1'b0);
      // abort in RUN after a start issued during LOAD
      job(9, 1, 0, 1'b0, 1'b1, 1'b0);
      // randomized jobs
      for (int k = 0; k < 3; k++) begin
         job($urandom_range(1, 40), $urandom_range(0, 4),
             $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      // reset in the middle of DRAIN, then recover
      job(5, 0, 3, 1'b0, 1'b0, 1'b1);
      job(9, 2, 0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
